// File: rtl/smaesh_host_adapter_pkg.sv
// Shared widths, FSM encodings and share-layout index helpers for the SMAesh host adapter.
package smaesh_host_adapter_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned CNT_W     = 2;

`ifdef HOST_KEY_REUSE_EN
  typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, PRESENT, RESHARE} in_state_e;
`else
  typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, PRESENT} in_state_e;
`endif

  typedef enum logic {IDLE, DRAIN} out_state_e;

  // Bit offset of word k inside a 128-bit block.
  function automatic int unsigned word_lsb(input int unsigned word);
    return WORD_W * word;
  endfunction

  // Bit offset of word k of share i in a d-share bus.
  function automatic int unsigned share_lsb(input int unsigned share, input int unsigned word);
    return BLOCK_W * share + WORD_W * word;
  endfunction

endpackage

// File: rtl/smaesh_unmask_serializer.sv
// Output path: recombines ciphertext shares, holds the 128-bit result and drains it as 4 words.
module smaesh_unmask_serializer
  import smaesh_host_adapter_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 aes_out_valid,
  output logic                 aes_out_ready,
  input  logic [BLOCK_W*d-1:0] aes_shares_ciphertext,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready
);

  out_state_e         state;
  logic [CNT_W-1:0]   idx;
  logic [BLOCK_W-1:0] ct;
  logic [BLOCK_W-1:0] unmasked;

  always_comb begin
    unmasked = '0;
    for (int unsigned i = 0; i < d; i++) begin
      unmasked ^= aes_shares_ciphertext[BLOCK_W*i +: BLOCK_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      ct    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aes_out_valid) begin
            ct    <= unmasked;
            idx   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            idx <= idx + CNT_W'(1);
            if (idx == CNT_W'(NUM_WORDS - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign aes_out_ready = ~rst & (state == IDLE);
  assign m_valid       = ~rst & (state == DRAIN);
  assign m_data        = ct[word_lsb(32'(idx)) +: WORD_W];

endmodule

// File: rtl/smaesh_host_adapter.sv
// Host adapter for a d-share masked AES core: shares host key/plaintext words, unmasks ciphertext.
// Optional HOST_KEY_REUSE_EN keeps the last key and re-shares it when s_reuse is set.
module smaesh_host_adapter
  import smaesh_host_adapter_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
`ifdef HOST_KEY_REUSE_EN
  input  logic                      s_reuse,
`endif
  input  logic [WORD_W*(d-1)-1:0]   rnd_data,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic                      aes_in_valid,
  input  logic                      aes_in_ready,
  output logic [BLOCK_W*d-1:0]      aes_shares_key,
  output logic [BLOCK_W*d-1:0]      aes_shares_plaintext,
  input  logic                      aes_out_valid,
  output logic                      aes_out_ready,
  input  logic [BLOCK_W*d-1:0]      aes_shares_ciphertext,
  output logic [WORD_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready
);

  in_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [BLOCK_W*d-1:0] key_sh;
  logic [BLOCK_W*d-1:0] pt_sh;
  logic                 accept;
  logic                 last_word;
  logic                 loading;

  // Writes word k of every share: shares 1..d-1 take the random slices, share 0 the masked word.
  function automatic logic [BLOCK_W*d-1:0] put_word(input logic [BLOCK_W*d-1:0]    sh,
                                                    input logic [CNT_W-1:0]        k,
                                                    input logic [WORD_W-1:0]       w,
                                                    input logic [WORD_W*(d-1)-1:0] r);
    logic [BLOCK_W*d-1:0] res;
    logic [WORD_W-1:0]    s0;
    res = sh;
    s0  = w;
    for (int unsigned j = 1; j < d; j++) begin
      res[share_lsb(j, 32'(k)) +: WORD_W] = r[WORD_W*(j-1) +: WORD_W];
      s0 ^= r[WORD_W*(j-1) +: WORD_W];
    end
    res[share_lsb(0, 32'(k)) +: WORD_W] = s0;
    return res;
  endfunction

  assign loading   = (state == LOAD_KEY) || (state == LOAD_PT);
  assign last_word = (cnt == CNT_W'(NUM_WORDS - 1));

`ifdef HOST_KEY_REUSE_EN
  logic [BLOCK_W-1:0] key_reg;
  logic               key_stored;
  logic               reuse_go;

  // The first word of a reuse transaction is held back until the stored key is re-shared.
  assign reuse_go  = (state == LOAD_KEY) && (cnt == '0) && s_valid && s_reuse && key_stored;
  assign s_ready   = ~rst & loading & rnd_valid & ~reuse_go;
  assign rnd_ready = (s_ready & s_valid) | (~rst & (state == RESHARE));
`else
  assign s_ready   = ~rst & loading & rnd_valid;
  assign rnd_ready = s_ready & s_valid;
`endif

  assign accept = s_ready & s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_KEY;
      cnt        <= '0;
      key_sh     <= '0;
      pt_sh      <= '0;
`ifdef HOST_KEY_REUSE_EN
      key_reg    <= '0;
      key_stored <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD_KEY: begin
`ifdef HOST_KEY_REUSE_EN
          if (reuse_go) begin
            state <= RESHARE;
            cnt   <= '0;
          end else
`endif
          if (accept) begin
            key_sh <= put_word(key_sh, cnt, s_data, rnd_data);
`ifdef HOST_KEY_REUSE_EN
            key_reg[word_lsb(32'(cnt)) +: WORD_W] <= s_data;
            if (last_word) key_stored <= 1'b1;
`endif
            cnt <= cnt + CNT_W'(1);
            if (last_word) state <= LOAD_PT;
          end
        end
`ifdef HOST_KEY_REUSE_EN
        RESHARE: begin
          if (rnd_valid) begin
            key_sh <= put_word(key_sh, cnt, key_reg[word_lsb(32'(cnt)) +: WORD_W], rnd_data);
            cnt    <= cnt + CNT_W'(1);
            if (last_word) state <= LOAD_PT;
          end
        end
`endif
        LOAD_PT: begin
          if (accept) begin
            pt_sh <= put_word(pt_sh, cnt, s_data, rnd_data);
            cnt   <= cnt + CNT_W'(1);
            if (last_word) state <= PRESENT;
          end
        end
        PRESENT: begin
          if (aes_in_ready) state <= LOAD_KEY;
        end
        default: state <= LOAD_KEY;
      endcase
    end
  end

  assign aes_in_valid         = ~rst & (state == PRESENT);
  assign aes_shares_key       = key_sh;
  assign aes_shares_plaintext = pt_sh;

  smaesh_unmask_serializer #(.d(d)) u_unmask (
    .clk                   (clk),
    .rst                   (rst),
    .aes_out_valid         (aes_out_valid),
    .aes_out_ready         (aes_out_ready),
    .aes_shares_ciphertext (aes_shares_ciphertext),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready)
  );

endmodule

// File: tb/tb_smaesh_host_adapter.sv
// Self-checking bench for smaesh_host_adapter (d=2): handshake table, directed corners, randomized traffic.
module tb_smaesh_host_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
`ifdef HOST_KEY_REUSE_EN
  logic         s_reuse;
`endif
  logic [31:0]  rnd_data;
  logic         rnd_valid;
  logic         rnd_ready;
  logic         aes_in_valid;
  logic         aes_in_ready;
  logic [255:0] aes_shares_key;
  logic [255:0] aes_shares_plaintext;
  logic         aes_out_valid;
  logic         aes_out_ready;
  logic [255:0] aes_shares_ciphertext;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  smaesh_host_adapter #(.d(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_data                (s_data),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
`ifdef HOST_KEY_REUSE_EN
    .s_reuse               (s_reuse),
`endif
    .rnd_data              (rnd_data),
    .rnd_valid             (rnd_valid),
    .rnd_ready             (rnd_ready),
    .aes_in_valid          (aes_in_valid),
    .aes_in_ready          (aes_in_ready),
    .aes_shares_key        (aes_shares_key),
    .aes_shares_plaintext  (aes_shares_plaintext),
    .aes_out_valid         (aes_out_valid),
    .aes_out_ready         (aes_out_ready),
    .aes_shares_ciphertext (aes_shares_ciphertext),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready)
  );

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Reference: share1 is the randomness itself, share0 the value masked by it.
  function automatic logic [255:0] model_shares(input logic [127:0] v, input logic [127:0] r);
    return {r, v ^ r};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one word; optionally starve randomness first for `stall` cycles.
  task automatic send(input logic [31:0] w, input logic [31:0] r, input int stall);
    int n;
    s_data = w; rnd_data = r; s_valid = 1'b1; rnd_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk1("starved_s_ready", s_ready, 1'b0);
      @(posedge clk); #1;
    end
    rnd_valid = 1'b1;
    #1;
    n = 0;
    while (s_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (s_ready !== 1'b1) chk1("send_timeout", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; rnd_valid = 1'b0;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] p,
                      input logic [127:0] rk, input logic [127:0] rp, input int max_stall);
    for (int i = 0; i < 4; i++)
      send(k[32*i +: 32], rk[32*i +: 32], max_stall > 0 ? int'($urandom_range(max_stall, 0)) : 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk1("in_valid_before_last", aes_in_valid, 1'b0);
      send(p[32*i +: 32], rp[32*i +: 32], max_stall > 0 ? int'($urandom_range(max_stall, 0)) : 0);
    end
    chk1("in_valid_latency", aes_in_valid, 1'b1);
    chkw("key_shares", aes_shares_key, model_shares(k, rk));
    chkw("pt_shares", aes_shares_plaintext, model_shares(p, rp));
  endtask

  task automatic accept_in();
    aes_in_ready = 1'b1;
    @(posedge clk); #1;
    aes_in_ready = 1'b0;
    chk1("in_valid_after_hs", aes_in_valid, 1'b0);
  endtask

  // Hand a shared ciphertext to the adapter and collect the unmasked words (mode 0: m_ready 1010).
  task automatic drain(input logic [127:0] c, input int mode);
    logic [127:0] x;
    logic [31:0]  got[4];
    logic [31:0]  held;
    logic         held_v;
    int           n;
    x = rand128();
    aes_shares_ciphertext = {x, c ^ x};
    aes_out_valid = 1'b1;
    #1;
    chk1("out_ready_idle", aes_out_ready, 1'b1);
    @(posedge clk); #1;
    aes_out_valid = 1'b0;
    aes_shares_ciphertext = rand128() == 128'd0 ? 256'd1 : {rand128(), rand128()};
    chk1("m_valid_latency", m_valid, 1'b1);
    chk1("out_ready_drain", aes_out_ready, 1'b0);
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      m_ready = (mode == 0) ? ((cyc % 2) == 0) : 1'($urandom_range(1, 0));
      #1;
      held_v = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          got[n] = m_data;
          n++;
        end else begin
          held = m_data; held_v = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (held_v) chkw("m_data_hold", 256'(m_data), 256'(held));
    end
    m_ready = 1'b0;
    chkw("drain_count", 256'(n), 256'(4));
    for (int i = 0; i < 4; i++) chkw("m_word", 256'(got[i]), 256'(c[32*i +: 32]));
    chk1("m_valid_end", m_valid, 1'b0);
    chk1("out_ready_end", aes_out_ready, 1'b1);
  endtask

  typedef struct {
    logic rst;
    logic sv;
    logic rv;
    logic exp_sr;
    logic exp_rr;
    logic exp_aor;
  } hs_vec_t;

  hs_vec_t vecs[5];

  initial begin
    logic [127:0] k, p, rk, rp, c;
    logic [255:0] key_save, pt_save;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; s_data = '0; s_valid = 1'b1; rnd_data = '0; rnd_valid = 1'b1;
    aes_in_ready = 1'b0; aes_out_valid = 1'b0; aes_shares_ciphertext = '0; m_ready = 1'b0;
`ifdef HOST_KEY_REUSE_EN
    s_reuse = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_rnd_ready", rnd_ready, 1'b0);
    chk1("rst_out_ready", aes_out_ready, 1'b0);
    chk1("rst_in_valid", aes_in_valid, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chkw("rst_key_sh", aes_shares_key, 256'd0);
    rst = 1'b0; s_valid = 1'b0; rnd_valid = 1'b0;

    // Handshake gating table, applied between clock edges so nothing is consumed.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; s_valid = vecs[i].sv; rnd_valid = vecs[i].rv;
      #1;
      chk1("tbl_s_ready", s_ready, vecs[i].exp_sr);
      chk1("tbl_rnd_ready", rnd_ready, vecs[i].exp_rr);
      chk1("tbl_out_ready", aes_out_ready, vecs[i].exp_aor);
      rst = 1'b0; s_valid = 1'b0; rnd_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Known-answer sharing with all-ones randomness.
    k = 128'h0f0e0d0c0b0a09080706050403020100;
    p = 128'hffeeddccbbaa99887766554433221100;
    load(k, p, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, 0);
    chkw("kat_key_s0_w0", 256'(aes_shares_key[31:0]), 256'(32'hFCFDFEFF));
    chkw("kat_pt_s0_w0", 256'(aes_shares_plaintext[31:0]), 256'(32'hCCDDEEFF));
    chkw("kat_key_s1", 256'(aes_shares_key[255:128]), 256'({4{32'hFFFFFFFF}}));

    // Core back-pressure: shares frozen, no words taken.
    key_save = aes_shares_key; pt_save = aes_shares_plaintext;
    s_data = 32'hDEADBEEF; s_valid = 1'b1; rnd_data = 32'h12345678; rnd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk1("stall_in_valid", aes_in_valid, 1'b1);
      chk1("stall_s_ready", s_ready, 1'b0);
      chkw("stall_key", aes_shares_key, key_save);
      chkw("stall_pt", aes_shares_plaintext, pt_save);
    end
    s_valid = 1'b0; rnd_valid = 1'b0;
    accept_in();

    // Ciphertext unmasking with alternating m_ready.
    drain({32'hA1B2C3D4, 32'h0badf00d, 32'h13579bdf, 32'h70b4c55a}, 0);

    // Randomness starvation after key word 1.
    k = rand128(); p = rand128(); rk = rand128(); rp = rand128();
    send(k[31:0], rk[31:0], 0);
    send(k[63:32], rk[63:32], 0);
    send(k[95:64], rk[95:64], 5);
    send(k[127:96], rk[127:96], 0);
    for (int i = 0; i < 4; i++) send(p[32*i +: 32], rp[32*i +: 32], 0);
    chk1("starve_in_valid", aes_in_valid, 1'b1);
    chkw("starve_key", aes_shares_key, model_shares(k, rk));
    chkw("starve_pt", aes_shares_plaintext, model_shares(p, rp));
    accept_in();

    // Randomized traffic with loading and draining overlapped.
    for (int t = 0; t < 6; t++) begin
      k = rand128(); p = rand128(); rk = rand128(); rp = rand128(); c = rand128();
      fork
        load(k, p, rk, rp, 2);
        drain(c, 1);
      join
      accept_in();
    end

    // Reset mid-transaction while a drain is pending.
    aes_shares_ciphertext = {rand128(), rand128()};
    aes_out_valid = 1'b1;
    @(posedge clk); #1;
    aes_out_valid = 1'b0;
    chk1("pre_rst_m_valid", m_valid, 1'b1);
    k = rand128(); p = rand128(); rk = rand128(); rp = rand128();
    for (int i = 0; i < 4; i++) send(k[32*i +: 32], rk[32*i +: 32], 0);
    for (int i = 0; i < 2; i++) send(p[32*i +: 32], rp[32*i +: 32], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("post_rst_m_valid", m_valid, 1'b0);
    chk1("post_rst_in_valid", aes_in_valid, 1'b0);
    chkw("post_rst_key", aes_shares_key, 256'd0);
    chkw("post_rst_pt", aes_shares_plaintext, 256'd0);
    k = rand128(); p = rand128(); rk = rand128(); rp = rand128();
    load(k, p, rk, rp, 1);
    accept_in();

`ifdef HOST_KEY_REUSE_EN
    // Stored key re-shared with fresh randomness; only plaintext words sent.
    key_save = aes_shares_key;
    p = rand128();
    rk = {4{32'h5A5A5A5A}};
    s_reuse = 1'b1;
    send(p[31:0], 32'h5A5A5A5A, 0);
    s_reuse = 1'b0;
    for (int i = 1; i < 4; i++) send(p[32*i +: 32], 32'h5A5A5A5A, 0);
    chk1("reuse_in_valid", aes_in_valid, 1'b1);
    chkw("reuse_key_xor", 256'(aes_shares_key[255:128] ^ aes_shares_key[127:0]), 256'(k));
    chk1("reuse_new_shares", aes_shares_key[255:128] != key_save[255:128], 1'b1);
    chkw("reuse_pt", aes_shares_plaintext, model_shares(p, rk));
    accept_in();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
